pwm_cfg_sequencer: RTL and testbench
====================================

// Module: pwm_cfg_sequencer
// PURPOSE
//   Configuration and sequencing controller for the modulable PWM core in tt_um_pwm_top.
//   Accepts byte writes from the pin interface into shadow registers.
//   Commits them to the PWM datapath only on a period boundary, so there are no glitched cycles.
//   Optionally ramps duty toward a target by a programmable step once per period (soft start/fade).
// PARAMETERS
//   WIDTH       8     bit width of period, duty and step registers
//   PERIOD_RST  8'hFF reset value of period_o (and of the period shadow register)
// PORTS
//   clk           in   1      system clock; all logic on rising edge
//   rst_n         in   1      reset, asynchronous assert, active-low
//   ena           in   1      design select; 0 = ignore writes, hold all state
//   wr_en         in   1      write strobe; one write per cycle it is high
//   wr_addr       in   2      0=CTRL{b1 ramp_mode, b0 enable} 1=PERIOD 2=DUTY target 3=STEP
//   wr_data       in   WIDTH  write data (CTRL uses bits [1:0] only)
//   period_end    in   1      1-cycle pulse from PWM counter on its last count of a period
//   period_o      out  WIDTH  active period to PWM core
//   duty_o        out  WIDTH  active duty to PWM core
//   pwm_en_o      out  1      active enable to PWM core
//   pending_o     out  1      shadow differs from active (commit outstanding)
//   ramping_o     out  1      high while in state RAMP
// BEHAVIOUR
//   Reset: period_o=PERIOD_RST, duty_o=0, pwm_en_o=0, pending_o=0, ramping_o=0.
//     Shadows reset to CTRL=0, PERIOD=PERIOD_RST, DUTY=0, STEP=1; state=OFF.
//     Reset mid-operation clears everything immediately; no partial commit survives.
//   Writes: when ena&wr_en, the shadow at wr_addr takes wr_data on the next edge.
//     pending_o=1 from that edge on.
//     ena=0: writes are dropped; period_end is ignored; outputs and state frozen.
//   FSM states: OFF, RUN, RAMP. All outputs are registered.
//   OFF (pwm_en_o=0): the PWM counter gives no boundaries, so a pending commit applies on the next edge.
//     Period and duty are copied; pwm_en_o is set from CTRL.enable.
//     duty_o = ramp_mode ? 0 : target.
//     Next state: enable=0 -> OFF; ramp_mode=1 -> RAMP; else -> RUN.
//   RUN: on period_end with pending=1, commit shadows.
//     period_o<=PERIOD; pwm_en_o<=enable; duty_o<=target (ramp_mode=0).
//     enable=0 -> OFF with duty_o<=0.
//     ramp_mode=1 -> RAMP, duty_o unchanged on that edge.
//   RAMP: on each period_end, period_o and pwm_en_o commit as in RUN.
//     duty_o moves toward the current target by STEP and saturates at target (never overshoots).
//     Up: duty+STEP >= target -> target. Down: duty-STEP <= target -> target.
//     Arithmetic is WIDTH+1 bits, so there is no wrap.
//     STEP=0 is treated as 1.
//     duty_o==target with pending=0 -> RUN on the same edge.
//     Target rewritten mid-ramp: the ramp re-aims from the current duty_o.
//     ramp_mode cleared -> jump to target on the next period_end, then RUN.
//   Clamp: the committed duty is min(duty, period); the target itself is also clamped.
//     A clamped duty yields 100% high, never a wrapped value.
//   pending_o clears on the commit edge when no write lands in that same cycle.
//   In RAMP, pending_o stays 1 until duty_o==target.
//   Simultaneous wr_en and period_end: the commit uses pre-write shadow values.
//     The new byte stays in the shadow and pending_o stays 1 for the next boundary.
//   Latency: 1 cycle from write to pending_o.
//     Commit <= 1 cycle in OFF; otherwise the edge after the next period_end pulse.
// TESTING
//   Reset: assert rst_n=0 mid-ramp -> immediately period_o=FF, duty_o=0, pwm_en_o=0, pending_o=0.
//   OFF commit: write PERIOD=99, DUTY=50, CTRL=01 -> outputs 99/50/1 one cycle after the CTRL write, state RUN.
//   RUN sync: in RUN, write DUTY=20 -> duty_o holds 50 until period_end, then 20; pending_o 1->0.
//   Ramp: STEP=16, DUTY=40, CTRL=11 from duty 0 -> duty 16,32,40 on 3 period_ends, then ramping_o=0.
//   Boundaries: DUTY=200 with PERIOD=99 -> duty_o=99.
//     Write coinciding with period_end -> applied at the next period_end.
//     ena=0 -> writes ignored.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// Shadow-register configuration front end for the PWM core: byte writes land in shadows and
// are committed on period boundaries, with an optional once-per-period duty ramp toward the target.
module pwm_cfg_sequencer #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PERIOD_RST = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             period_end,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             pwm_en_o,
  output logic             pending_o,
  output logic             ramping_o
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_RAMP} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ctrl_reg, ctrl_next;
  logic [WIDTH-1:0] period_sh_reg, period_sh_next;
  logic [WIDTH-1:0] target_sh_reg, target_sh_next;
  logic [WIDTH-1:0] step_sh_reg, step_sh_next;
  logic             pending_reg, pending_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] duty_reg, duty_next;
  logic             pwm_en_reg, pwm_en_next;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic             wr;
  logic [WIDTH-1:0] eff_target, step_eff, ramp_raw, ramp_duty, hold_duty;
  logic [WIDTH:0]   duty_ext, tgt_ext, step_ext, up_sum, dn_reach;

  assign wr         = ena & wr_en;
  assign eff_target = clamp(target_sh_reg, period_sh_reg);
  assign step_eff   = (step_sh_reg == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step_sh_reg;
  assign duty_ext   = {1'b0, duty_reg};
  assign tgt_ext    = {1'b0, eff_target};
  assign step_ext   = {1'b0, step_eff};
  // One extra bit keeps both the overshoot and undershoot tests free of wrap-around.
  assign up_sum     = duty_ext + step_ext;
  assign dn_reach   = tgt_ext + step_ext;
  assign hold_duty  = clamp(duty_reg, period_sh_reg);

  always_comb begin
    ramp_raw = eff_target;
    if (duty_ext < tgt_ext)
      ramp_raw = (up_sum >= tgt_ext) ? eff_target : up_sum[WIDTH-1:0];
    else if (duty_ext > tgt_ext)
      ramp_raw = (dn_reach >= duty_ext) ? eff_target : (duty_reg - step_eff);
    ramp_duty = clamp(ramp_raw, period_sh_reg);
  end

  always_comb begin
    state_next     = state_reg;
    ctrl_next      = ctrl_reg;
    period_sh_next = period_sh_reg;
    target_sh_next = target_sh_reg;
    step_sh_next   = step_sh_reg;
    pending_next   = pending_reg | wr;
    period_next    = period_reg;
    duty_next      = duty_reg;
    pwm_en_next    = pwm_en_reg;

    if (wr) begin
      case (wr_addr)
        2'd0:    ctrl_next      = wr_data[1:0];
        2'd1:    period_sh_next = wr_data;
        2'd2:    target_sh_next = wr_data;
        default: step_sh_next   = wr_data;
      endcase
    end

    // Commits always read the pre-write shadows; a same-cycle write only keeps pending set.
    if (ena) begin
      case (state_reg)
        ST_OFF: begin
          if (pending_reg) begin
            period_next  = period_sh_reg;
            pwm_en_next  = ctrl_reg[0];
            duty_next    = ctrl_reg[1] ? '0 : eff_target;
            pending_next = wr;
            if (!ctrl_reg[0]) begin
              state_next = ST_OFF;
            end else if (ctrl_reg[1]) begin
              state_next   = ST_RAMP;
              pending_next = wr | (eff_target != '0);
            end else begin
              state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (period_end && pending_reg) begin
            period_next  = period_sh_reg;
            pwm_en_next  = ctrl_reg[0];
            pending_next = wr;
            if (!ctrl_reg[0]) begin
              duty_next  = '0;
              state_next = ST_OFF;
            end else if (ctrl_reg[1]) begin
              duty_next    = hold_duty;
              state_next   = ST_RAMP;
              pending_next = wr | (hold_duty != eff_target);
            end else begin
              duty_next = eff_target;
            end
          end
        end
        ST_RAMP: begin
          if (period_end) begin
            period_next  = period_sh_reg;
            pwm_en_next  = ctrl_reg[0];
            pending_next = wr;
            if (!ctrl_reg[0]) begin
              duty_next  = '0;
              state_next = ST_OFF;
            end else if (!ctrl_reg[1]) begin
              duty_next  = eff_target;
              state_next = ST_RUN;
            end else begin
              duty_next = ramp_duty;
              if (ramp_duty == eff_target && !wr)
                state_next = ST_RUN;
              else
                pending_next = 1'b1;
            end
          end
        end
        default: state_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_OFF;
      ctrl_reg      <= 2'b00;
      period_sh_reg <= PERIOD_RST;
      target_sh_reg <= '0;
      step_sh_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
      pending_reg   <= 1'b0;
      period_reg    <= PERIOD_RST;
      duty_reg      <= '0;
      pwm_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ctrl_reg      <= ctrl_next;
      period_sh_reg <= period_sh_next;
      target_sh_reg <= target_sh_next;
      step_sh_reg   <= step_sh_next;
      pending_reg   <= pending_next;
      period_reg    <= period_next;
      duty_reg      <= duty_next;
      pwm_en_reg    <= pwm_en_next;
    end
  end

  assign period_o  = period_reg;
  assign duty_o    = duty_reg;
  assign pwm_en_o  = pwm_en_reg;
  assign pending_o = pending_reg;
  assign ramping_o = (state_reg == ST_RAMP);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: a per-cycle vector table followed by hand-written
// ramp, re-aim, ramp-cancel and asynchronous-reset sequences.
module tb_pwm_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       period_end = 1'b0;
  logic [7:0] period_o, duty_o;
  logic       pwm_en_o, pending_o, ramping_o;

  int checks = 0;
  int errors = 0;

  pwm_cfg_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .period_end(period_end),
    .period_o  (period_o),
    .duty_o    (duty_o),
    .pwm_en_o  (pwm_en_o),
    .pending_o (pending_o),
    .ramping_o (ramping_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       pe;
    logic [7:0] e_period;
    logic [7:0] e_duty;
    logic       e_en;
    logic       e_pend;
    logic       e_ramp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic w, input logic [1:0] a, input logic [7:0] d,
                     input logic p, input logic [7:0] ep, input logic [7:0] ed,
                     input logic een, input logic epd, input logic erp);
    vec_t v;
    v.ena = e; v.wr = w; v.addr = a; v.data = d; v.pe = p;
    v.e_period = ep; v.e_duty = ed; v.e_en = een; v.e_pend = epd; v.e_ramp = erp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] ep, input logic [7:0] ed,
                       input logic een, input logic epd, input logic erp);
    checks++;
    if (period_o !== ep) begin
      errors++; $display("FAIL %s period_o got %0d want %0d", name, period_o, ep);
    end
    checks++;
    if (duty_o !== ed) begin
      errors++; $display("FAIL %s duty_o got %0d want %0d", name, duty_o, ed);
    end
    checks++;
    if (pwm_en_o !== een) begin
      errors++; $display("FAIL %s pwm_en_o got %0b want %0b", name, pwm_en_o, een);
    end
    checks++;
    if (pending_o !== epd) begin
      errors++; $display("FAIL %s pending_o got %0b want %0b", name, pending_o, epd);
    end
    checks++;
    if (ramping_o !== erp) begin
      errors++; $display("FAIL %s ramping_o got %0b want %0b", name, ramping_o, erp);
    end
    $display("%-10s ena=%0b wr=%0b a=%0d d=%0d pe=%0b -> period=%0d duty=%0d en=%0b pend=%0b ramp=%0b",
             name, ena, wr_en, wr_addr, wr_data, period_end, period_o, duty_o, pwm_en_o,
             pending_o, ramping_o);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cyc(input string name, input logic e, input logic w, input logic [1:0] a,
                     input logic [7:0] d, input logic p, input logic [7:0] ep,
                     input logic [7:0] ed, input logic een, input logic epd, input logic erp);
    @(negedge clk);
    ena = e; wr_en = w; wr_addr = a; wr_data = d; period_end = p;
    @(posedge clk);
    #1;
    check(name, ep, ed, een, epd, erp);
  endtask

  initial begin
    // ena wr addr data pe | period duty en pend ramp
    // OFF commit: PERIOD=99, DUTY=50, CTRL=01, each write commits the pre-write shadows
    add(1'b1, 1'b1, 2'd1, 8'd99,  1'b0, 8'd255, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd2, 8'd50,  1'b0, 8'd99,  8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd0, 8'd1,   1'b0, 8'd99,  8'd50, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 8'd99,  8'd50, 1'b1, 1'b0, 1'b0);
    // RUN: new duty waits for period_end
    add(1'b1, 1'b1, 2'd2, 8'd20,  1'b0, 8'd99,  8'd50, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 8'd99,  8'd50, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd20, 1'b1, 1'b0, 1'b0);
    // Duty above period is clamped
    add(1'b1, 1'b1, 2'd2, 8'd200, 1'b0, 8'd99,  8'd20, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd99, 1'b1, 1'b0, 1'b0);
    // Write coinciding with period_end commits the old target, new one next boundary
    add(1'b1, 1'b1, 2'd2, 8'd30,  1'b0, 8'd99,  8'd99, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd2, 8'd10,  1'b1, 8'd99,  8'd30, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd10, 1'b1, 1'b0, 1'b0);
    // ena=0 drops the write and ignores period_end
    add(1'b0, 1'b1, 2'd2, 8'd5,   1'b1, 8'd99,  8'd10, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd10, 1'b1, 1'b0, 1'b0);
    // STEP=0 behaves as 1: ramp down 10 -> 9 -> 8 -> 7 then RUN
    add(1'b1, 1'b1, 2'd3, 8'd0,   1'b0, 8'd99,  8'd10, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd2, 8'd7,   1'b0, 8'd99,  8'd10, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd0, 8'd3,   1'b0, 8'd99,  8'd10, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd10, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd9,  1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd8,  1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd7,  1'b1, 1'b0, 1'b0);
    // Disable from RUN goes to OFF with duty 0
    add(1'b1, 1'b1, 2'd0, 8'd0,   1'b0, 8'd99,  8'd7,  1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 8'd0,   1'b1, 8'd99,  8'd0,  1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc($sformatf("vec%0d", i), vecs[i].ena, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].pe,
          vecs[i].e_period, vecs[i].e_duty, vecs[i].e_en, vecs[i].e_pend, vecs[i].e_ramp);
    end

    // Ramp up from 0: STEP=16, DUTY=40, CTRL=11 -> 16, 32, 40 then RUN
    cyc("rmp_step", 1'b1, 1'b1, 2'd3, 8'd16, 1'b0, 8'd99, 8'd0,  1'b0, 1'b1, 1'b0);
    cyc("rmp_duty", 1'b1, 1'b1, 2'd2, 8'd40, 1'b0, 8'd99, 8'd7,  1'b0, 1'b1, 1'b0);
    cyc("rmp_ctrl", 1'b1, 1'b1, 2'd0, 8'd3,  1'b0, 8'd99, 8'd40, 1'b0, 1'b1, 1'b0);
    cyc("rmp_go",   1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 8'd99, 8'd0,  1'b1, 1'b1, 1'b1);
    cyc("rmp_hold", 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 8'd99, 8'd0,  1'b1, 1'b1, 1'b1);
    cyc("rmp_16",   1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd16, 1'b1, 1'b1, 1'b1);
    cyc("rmp_32",   1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd32, 1'b1, 1'b1, 1'b1);
    cyc("rmp_40",   1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd40, 1'b1, 1'b0, 1'b0);

    // Re-aim mid-ramp (90 then 50), then cancel ramp_mode and jump to target
    cyc("aim_90",   1'b1, 1'b1, 2'd2, 8'd90, 1'b0, 8'd99, 8'd40, 1'b1, 1'b1, 1'b0);
    cyc("aim_ent",  1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd40, 1'b1, 1'b1, 1'b1);
    cyc("aim_56",   1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd56, 1'b1, 1'b1, 1'b1);
    cyc("aim_72",   1'b1, 1'b1, 2'd2, 8'd50, 1'b1, 8'd99, 8'd72, 1'b1, 1'b1, 1'b1);
    cyc("aim_dn56", 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd56, 1'b1, 1'b1, 1'b1);
    cyc("cancel",   1'b1, 1'b1, 2'd0, 8'd1,  1'b0, 8'd99, 8'd56, 1'b1, 1'b1, 1'b1);
    cyc("jump_50",  1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd50, 1'b1, 1'b0, 1'b0);

    // Reset asserted mid-ramp takes effect without a clock edge
    cyc("rr_ctrl",  1'b1, 1'b1, 2'd0, 8'd3,  1'b0, 8'd99, 8'd50, 1'b1, 1'b1, 1'b0);
    cyc("rr_duty",  1'b1, 1'b1, 2'd2, 8'd90, 1'b0, 8'd99, 8'd50, 1'b1, 1'b1, 1'b0);
    cyc("rr_ent",   1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd50, 1'b1, 1'b1, 1'b1);
    cyc("rr_66",    1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd99, 8'd66, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Nothing survives: a boundary commits nothing, and shadows are back to reset values
    cyc("post_pe",  1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc("post_en",  1'b1, 1'b1, 2'd0, 8'd1,  1'b0, 8'd255, 8'd0, 1'b0, 1'b1, 1'b0);
    cyc("post_run", 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
